// File: rtl/sram256x8_arbiter.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module      : sram256x8_arbiter
//  Description : Controller and two-port arbiter for one single-port 256x8
//                SRAM macro. After reset it writes INIT_VALUE to every word,
//                then shares the macro between two valid/ready requesters
//                using round-robin or fixed-priority arbitration. Read data
//                returns with a fixed latency of one cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module sram256x8_arbiter #(
  parameter int                ADDR_W     = 8,
  parameter int                DATA_W     = 8,
  parameter int                INIT_EN    = 1,
  parameter logic [DATA_W-1:0] INIT_VALUE = '0,
  parameter int                RR_EN      = 1,
  parameter int                CNT_W      = 16
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [1:0]          req_write,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic [1:0]          resp_valid,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                init_done,
  output logic [CNT_W-1:0]    conflict_cnt,
  output logic [ADDR_W-1:0]   sram_A,
  output logic [DATA_W-1:0]   sram_I,
  input  logic [DATA_W-1:0]   sram_O,
  output logic                sram_CSB,
  output logic                sram_WEB,
  output logic                sram_OEB
);

  localparam int c_DEPTH = 2 ** ADDR_W;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam state_t c_RESET_STATE = (INIT_EN != 0) ? ST_INIT : ST_RUN;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_init_cnt;
  logic                r_rr_ptr;
  logic [1:0]          r_resp_valid;
  logic [CNT_W-1:0]    r_conflict_cnt;
  logic [ADDR_W-1:0]   r_a_hold;
  logic [DATA_W-1:0]   r_i_hold;

  logic [1:0]          w_grant;
  logic                w_gsel;
  logic                w_init_last;
  logic                w_csb;
  logic                w_web;
  logic                w_oeb;
  logic [ADDR_W-1:0]   w_a;
  logic [DATA_W-1:0]   w_i;

  assign w_init_last = (r_init_cnt == ADDR_W'(c_DEPTH - 1));

  // State register and sweep address counter
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= c_RESET_STATE;
      r_init_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_INIT) begin
        r_init_cnt <= r_init_cnt + 1'b1;
      end
    end
  end

  // Next state, arbitration and macro drive; idle keeps A/I at the last driven value
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 2'b00;
    w_gsel      = 1'b0;
    w_csb       = 1'b1;
    w_web       = 1'b1;
    w_oeb       = 1'b1;
    w_a         = r_a_hold;
    w_i         = r_i_hold;
    case (r_state)
      ST_INIT: begin
        w_csb = 1'b0;
        w_web = 1'b0;
        w_a   = r_init_cnt;
        w_i   = INIT_VALUE;
        if (w_init_last) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (req_valid == 2'b11) begin
          w_gsel  = (RR_EN != 0) ? r_rr_ptr : 1'b0;
          w_grant = w_gsel ? 2'b10 : 2'b01;
        end else if (req_valid[0]) begin
          w_gsel  = 1'b0;
          w_grant = 2'b01;
        end else if (req_valid[1]) begin
          w_gsel  = 1'b1;
          w_grant = 2'b10;
        end
        if (w_grant != 2'b00) begin
          w_csb = 1'b0;
          w_a   = w_gsel ? req_addr[2*ADDR_W-1:ADDR_W]  : req_addr[ADDR_W-1:0];
          w_i   = w_gsel ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
          w_web = ~req_write[w_gsel];
          w_oeb =  req_write[w_gsel];
        end
      end
      default: begin
        w_state_nxt = c_RESET_STATE;
      end
    endcase
  end

  // Round-robin pointer, read-response strobe and held macro address/data
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rr_ptr     <= 1'b0;
      r_resp_valid <= 2'b00;
      r_a_hold     <= '0;
      r_i_hold     <= '0;
    end else begin
      if (w_grant != 2'b00) begin
        r_rr_ptr <= ~w_gsel;
      end
      r_resp_valid <= w_grant & ~req_write;
      r_a_hold     <= w_a;
      r_i_hold     <= w_i;
    end
  end

  // Saturating count of RUN cycles where both ports request
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_conflict_cnt <= '0;
    end else if ((r_state == ST_RUN) && (req_valid == 2'b11) &&
                 (r_conflict_cnt != {CNT_W{1'b1}})) begin
      r_conflict_cnt <= r_conflict_cnt + 1'b1;
    end
  end

  // Controls are forced inactive while reset is asserted, without waiting for a clock
  assign req_ready    = w_grant & {2{reset_n}};
  assign sram_CSB     = w_csb | ~reset_n;
  assign sram_WEB     = w_web | ~reset_n;
  assign sram_OEB     = w_oeb | ~reset_n;
  assign sram_A       = w_a;
  assign sram_I       = w_i;
  assign resp_valid   = r_resp_valid;
  assign resp_rdata   = sram_O;
  assign init_done    = (r_state == ST_RUN);
  assign conflict_cnt = r_conflict_cnt;

endmodule
`default_nettype wire

// File: tb/tb_sram256x8_arbiter.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module      : tb_sram256x8_arbiter
//  Description : Bench for sram256x8_arbiter. Two instances share stimulus:
//                dut0 round-robin with a 16-bit counter, dut1 fixed priority
//                with a 4-bit counter. Each has its own behavioural macro.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sram256x8_arbiter;

  localparam logic [7:0] c_INITV = 8'hA5;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_write = 2'b00;
  logic [15:0] req_addr = '0;
  logic [15:0] req_wdata = '0;

  logic [1:0]  rdy0, rv0, rdy1, rv1;
  logic [7:0]  rd0, rd1, a0, a1, i0, i1;
  logic [7:0]  o0 = '0;
  logic [7:0]  o1 = '0;
  logic        done0, done1, csb0, csb1, web0, web1, oeb0, oeb1;
  logic [15:0] conf0;
  logic [3:0]  conf1;
  logic [1:0]  rdy0_s, rdy1_s;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  sram256x8_arbiter #(.ADDR_W(8), .DATA_W(8), .INIT_EN(1), .INIT_VALUE(c_INITV),
                      .RR_EN(1), .CNT_W(16)) dut0 (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(rdy0),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv0), .resp_rdata(rd0), .init_done(done0), .conflict_cnt(conf0),
    .sram_A(a0), .sram_I(i0), .sram_O(o0), .sram_CSB(csb0), .sram_WEB(web0),
    .sram_OEB(oeb0));

  sram256x8_arbiter #(.ADDR_W(8), .DATA_W(8), .INIT_EN(1), .INIT_VALUE(c_INITV),
                      .RR_EN(0), .CNT_W(4)) dut1 (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(rdy1),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv1), .resp_rdata(rd1), .init_done(done1), .conflict_cnt(conf1),
    .sram_A(a1), .sram_I(i1), .sram_O(o1), .sram_CSB(csb1), .sram_WEB(web1),
    .sram_OEB(oeb1));

  // Behavioural single-port macros (registered read port)
  logic [7:0] mem0 [256];
  logic [7:0] mem1 [256];
  always @(posedge clock) begin
    if (!csb0 && !web0) mem0[a0] <= i0;
    if (!csb0 && !oeb0) o0 <= mem0[a0];
    if (!csb1 && !web1) mem1[a1] <= i1;
    if (!csb1 && !oeb1) o1 <= mem1[a1];
  end

  // Reference model: per-instance memory image, sweep progress, tie preference,
  // pending response and conflict total
  logic [7:0] m_mem [2][256];
  int         m_sweep [2];
  bit         m_run [2];
  int         m_pref [2];
  logic [1:0] m_rv [2];
  logic [7:0] m_rd [2];
  int         m_conf [2];

  function automatic int cmax(input int d);
    return (d == 0) ? 65535 : 15;
  endfunction

  // Which port the rules say wins this cycle (-1 = none)
  function automatic int exp_grant(input int d);
    if (!reset_n || !m_run[d] || req_valid == 2'b00) return -1;
    if (req_valid == 2'b01) return 0;
    if (req_valid == 2'b10) return 1;
    return (d == 0) ? m_pref[d] : 0;
  endfunction

  // Model advance at each clock edge; async reset clears it
  always @(posedge clock or negedge reset_n) begin
    int g;
    logic [7:0] adr;
    if (!reset_n) begin
      for (int d = 0; d < 2; d++) begin
        m_sweep[d] = 0; m_run[d] = 1'b0; m_pref[d] = 0;
        m_rv[d] = 2'b00; m_conf[d] = 0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        g = exp_grant(d);
        m_rv[d] = 2'b00;
        if (!m_run[d]) begin
          m_mem[d][m_sweep[d][7:0]] = c_INITV;
          if (m_sweep[d] == 255) m_run[d] = 1'b1;
          m_sweep[d] = m_sweep[d] + 1;
        end else begin
          if (req_valid == 2'b11 && m_conf[d] < cmax(d)) m_conf[d] = m_conf[d] + 1;
          if (g >= 0) begin
            adr = req_addr[g*8 +: 8];
            if (req_write[g]) m_mem[d][adr] = req_wdata[g*8 +: 8];
            else begin
              m_rv[d][g] = 1'b1;
              m_rd[d] = m_mem[d][adr];
            end
            m_pref[d] = 1 - g;
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input int d, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s dut%0d: got %0h, expected %0h (t=%0t)", nm, d, act, exp, $time);
    end
  endtask

  task automatic check_dut(input int d, input logic [1:0] rdy, input logic [1:0] rv,
                           input logic [7:0] rd, input logic done, input logic [15:0] conf,
                           input logic csb, input logic web, input logic oeb,
                           input logic [7:0] a, input logic [7:0] i);
    int g;
    logic [1:0] e_rdy;
    if (!reset_n) begin
      chk("rst_ready", d, 32'(rdy), 0);  chk("rst_resp", d, 32'(rv), 0);
      chk("rst_done", d, 32'(done), 0);  chk("rst_conf", d, 32'(conf), 0);
      chk("rst_csb", d, 32'(csb), 1);    chk("rst_web", d, 32'(web), 1);
      chk("rst_oeb", d, 32'(oeb), 1);
      return;
    end
    if (!m_run[d]) begin
      chk("init_ready", d, 32'(rdy), 0); chk("init_resp", d, 32'(rv), 0);
      chk("init_done", d, 32'(done), 0); chk("init_csb", d, 32'(csb), 0);
      chk("init_web", d, 32'(web), 0);   chk("init_oeb", d, 32'(oeb), 1);
      chk("init_addr", d, 32'(a), 32'(m_sweep[d]));
      chk("init_data", d, 32'(i), 32'(c_INITV));
      chk("init_conf", d, 32'(conf), 32'(m_conf[d]));
      return;
    end
    g = exp_grant(d);
    e_rdy = (g < 0) ? 2'b00 : ((g == 0) ? 2'b01 : 2'b10);
    chk("run_ready", d, 32'(rdy), 32'(e_rdy));
    chk("run_resp", d, 32'(rv), 32'(m_rv[d]));
    if (m_rv[d] != 2'b00) chk("run_rdata", d, 32'(rd), 32'(m_rd[d]));
    chk("run_done", d, 32'(done), 1);
    chk("run_conf", d, 32'(conf), 32'(m_conf[d]));
    chk("run_csb", d, 32'(csb), (g < 0) ? 1 : 0);
    if (g >= 0) begin
      chk("run_web", d, 32'(web), 32'(!req_write[g]));
      chk("run_oeb", d, 32'(oeb), 32'(req_write[g]));
      chk("run_addr", d, 32'(a), 32'(req_addr[g*8 +: 8]));
      chk("run_wdata", d, 32'(i), 32'(req_wdata[g*8 +: 8]));
    end else begin
      chk("idle_web", d, 32'(web), 1);
      chk("idle_oeb", d, 32'(oeb), 1);
    end
  endtask

  // Every cycle, away from the active edge, compare both instances with the model
  always @(negedge clock) begin
    check_dut(0, rdy0, rv0, rd0, done0, conf0, csb0, web0, oeb0, a0, i0);
    check_dut(1, rdy1, rv1, rd1, done1, {12'h000, conf1}, csb1, web1, oeb1, a1, i1);
  end

  // Apply one cycle of stimulus; starts and ends 1 ns after a rising edge
  task automatic step(input logic [1:0] v, input logic [1:0] w, input logic [7:0] ad0,
                      input logic [7:0] ad1, input logic [7:0] wd0, input logic [7:0] wd1);
    req_valid = v; req_write = w; req_addr = {ad1, ad0}; req_wdata = {wd1, wd0};
    #3;
    rdy0_s = rdy0; rdy1_s = rdy1;
    @(posedge clock); #1;
  endtask

  initial begin
    logic [1:0] e;
    repeat (3) @(posedge clock);
    #2 reset_n = 1'b1;
    req_valid = 2'b11;

    // Sweep: requests held during INIT must not be accepted
    for (int k = 1; k <= 256; k++) begin
      @(posedge clock); #1;
      if (k == 200) req_valid = 2'b00;
      if (k == 255) chk("init_done_before_256", 0, 32'(done0), 0);
    end
    chk("init_done_at_256", 0, 32'(done0), 1);
    chk("init_done_at_256", 1, 32'(done1), 1);
    chk("no_conflict_in_init", 0, 32'(conf0), 0);

    // Swept contents at the boundaries and the middle
    step(2'b01, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
    chk("read_addr0", 0, 32'(rv0), 32'h1); chk("read_addr0_data", 0, 32'(rd0), 32'hA5);
    step(2'b01, 2'b00, 8'hFF, 8'h00, 8'h00, 8'h00);
    chk("read_addr255_data", 0, 32'(rd0), 32'hA5);
    step(2'b10, 2'b00, 8'h00, 8'h80, 8'h00, 8'h00);
    chk("read_addr128", 0, 32'(rv0), 32'h2); chk("read_addr128_data", 0, 32'(rd0), 32'hA5);

    // Write then read the same address on the next cycle
    step(2'b01, 2'b01, 8'h10, 8'h00, 8'h3C, 8'h00);
    chk("write_no_resp", 0, 32'(rv0), 0);
    step(2'b01, 2'b00, 8'h10, 8'h00, 8'h00, 8'h00);
    chk("wr_rd_resp", 0, 32'(rv0), 32'h1); chk("wr_rd_data", 0, 32'(rd0), 32'h3C);
    chk("wr_rd_data", 1, 32'(rd1), 32'h3C);
    step(2'b10, 2'b10, 8'h00, 8'h20, 8'h00, 8'h5A);

    // Both ports reading for four cycles
    for (int k = 0; k < 4; k++) begin
      step(2'b11, 2'b00, 8'h10, 8'h20, 8'h00, 8'h00);
      e = (k % 2 == 0) ? 2'b01 : 2'b10;
      chk("rr_ready", 0, 32'(rdy0_s), 32'(e));
      chk("rr_resp", 0, 32'(rv0), 32'(e));
      chk("rr_rdata", 0, 32'(rd0), (k % 2 == 0) ? 32'h3C : 32'h5A);
      chk("fixed_ready", 1, 32'(rdy1_s), 32'h1);
      chk("fixed_resp", 1, 32'(rv1), 32'h1);
      chk("fixed_rdata", 1, 32'(rd1), 32'h3C);
    end
    chk("conflict_after_4", 0, 32'(conf0), 4);
    chk("conflict_after_4", 1, 32'(conf1), 4);

    // Extended contention: the 4-bit counter saturates at 15
    for (int k = 1; k <= 20; k++) begin
      step(2'b11, 2'b00, 8'h10, 8'h20, 8'h00, 8'h00);
      if (k == 12) chk("conflict_sat_reached", 1, 32'(conf1), 15);
    end
    chk("conflict_sat_hold", 1, 32'(conf1), 15);
    chk("conflict_wide_24", 0, 32'(conf0), 24);
    step(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);

    // Reset in the middle of the sweep
    reset_n = 1'b0;
    @(posedge clock); #2 reset_n = 1'b1;
    for (int k = 1; k <= 100; k++) @(posedge clock);
    #1;
    chk("sweep_at_100_addr", 0, 32'(a0), 100);
    chk("sweep_at_100_csb", 0, 32'(csb0), 0);
    #1 reset_n = 1'b0;
    #1;
    chk("rst_async_csb", 0, 32'(csb0), 1);
    chk("rst_async_web", 0, 32'(web0), 1);
    @(posedge clock); #2 reset_n = 1'b1;
    #1;
    chk("sweep_restart_addr", 0, 32'(a0), 0);
    chk("sweep_restart_csb", 0, 32'(csb0), 0);
    for (int k = 1; k <= 256; k++) @(posedge clock);
    #1;
    chk("init_done_again", 0, 32'(done0), 1);

    // Reset while a read response is on the bus
    step(2'b01, 2'b00, 8'h05, 8'h00, 8'h00, 8'h00);
    chk("pre_rst_resp", 0, 32'(rv0), 32'h1); chk("pre_rst_rdata", 0, 32'(rd0), 32'hA5);
    #1 reset_n = 1'b0;
    #1;
    chk("rst_drops_resp", 0, 32'(rv0), 0);
    chk("rst_read_csb", 0, 32'(csb0), 1);
    chk("rst_read_ready", 0, 32'(rdy0), 0);
    @(posedge clock); #2 reset_n = 1'b1; req_valid = 2'b00;
    @(posedge clock); #1;
    chk("no_resp_after_rst", 0, 32'(rv0), 0);
    chk("no_resp_after_rst", 1, 32'(rv1), 0);
    repeat (3) @(posedge clock);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
